btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 150 +++++++++++++++
 tb/tb_btn_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizes and debounces a raw button level, then
// derives a press pulse, a typematic auto-repeat pulse train and a long-press
// level. All counters are CNTW bits wide. A timing constant must lie in the
// range 1..2^CNTW-1, because the counters never wrap.
module btn_conditioner #(
  parameter int DB_CYC  = 400000,    // debounce window, clk cycles
  parameter int RPT_DLY = 20000000,  // hold time before the first repeat
  parameter int RPT_PER = 4000000,   // auto-repeat period
  parameter int CNTW    = 25         // width of every internal counter
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn,
  output logic btn_dn,
  output logic btn_rpt,
  output logic btn_long
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] DB_LAST  = CNTW'(DB_CYC - 1);
  localparam logic [CNTW-1:0] DLY_LAST = CNTW'(RPT_DLY - 1);
  localparam logic [CNTW-1:0] PER_LAST = CNTW'(RPT_PER - 1);

  logic            s1;
  logic            s2;
  logic [CNTW-1:0] db_cnt;
  logic            db_done;
  logic            rise;
  logic            fall;

  state_t          state;
  state_t          state_next;
  logic [CNTW-1:0] rpt_cnt;
  logic [CNTW-1:0] rpt_cnt_next;
  logic            rpt_tick;
  logic            long_next;

  // Two-flop synchronizer; nothing else looks at btn_raw.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // flop samples the pre-edge value of its neighbours (s2 gets the old s1).
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // The debounced level flips on the DB_CYC-th consecutive edge at which the
  // synchronized input disagrees with it.
  assign db_done = (s2 != btn) && (db_cnt == DB_LAST);
  assign rise    = db_done && s2;
  assign fall    = db_done && !s2;

  // Debounce counter and the debounced level it qualifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      btn    <= 1'b0;
    end else if (s2 == btn) begin
      db_cnt <= '0;
    end else if (db_done) begin
      db_cnt <= '0;
      btn    <= s2;
    end else begin
      db_cnt <= db_cnt + CNT_ONE;
    end
  end

  // Repeat FSM next-state logic: one shared counter times both the initial
  // delay and the repeat period. Release wins over a coinciding repeat tick.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next   = state;
    rpt_cnt_next = rpt_cnt;
    rpt_tick     = 1'b0;
    unique case (state)
      IDLE: begin
        rpt_cnt_next = '0;
        if (rise) begin
          state_next = DELAY;
          rpt_tick   = 1'b1;
        end
      end
      DELAY: begin
        if (fall) begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end else if (rpt_cnt == DLY_LAST) begin
          state_next   = REPEAT;
          rpt_cnt_next = '0;
          rpt_tick     = 1'b1;
        end else begin
          rpt_cnt_next = rpt_cnt + CNT_ONE;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end else if (rpt_cnt == PER_LAST) begin
          rpt_cnt_next = '0;
          rpt_tick     = 1'b1;
        end else begin
          rpt_cnt_next = rpt_cnt + CNT_ONE;
        end
      end
      default: begin
        state_next   = IDLE;
        rpt_cnt_next = '0;
      end
    endcase
    long_next = (state_next == REPEAT);
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_next;
      rpt_cnt <= rpt_cnt_next;
    end
  end

  // Registered outputs, aligned with the edge on which btn itself changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_dn   <= 1'b0;
      btn_rpt  <= 1'b0;
      btn_long <= 1'b0;
    end else begin
      btn_dn   <= rise;
      btn_rpt  <= rpt_tick;
      btn_long <= long_next;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with short timing constants. A reference model
// derives the expected outputs for every clock edge and queues them; a
// monitor pops one entry per cycle and compares.
module tb_btn_conditioner;

  localparam int DB_CYC  = 4;
  localparam int RPT_DLY = 10;
  localparam int RPT_PER = 3;
  localparam int CNTW    = 8;
  localparam int HMAX    = 8192;

  typedef struct {
    int   edge_no;
    logic btn;
    logic dn;
    logic rpt;
    logic lng;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic btn;
  logic btn_dn;
  logic btn_rpt;
  logic btn_long;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   pushes = 0;
  int   pops = 0;
  int   edge_cnt = -1;

  // Raw level seen by each edge (forced to 0 where reset clears the synchronizer).
  logic hist[HMAX];
  logic m_btn = 1'b0;
  int   t_press = 0;

  btn_conditioner #(
    .DB_CYC (DB_CYC),
    .RPT_DLY(RPT_DLY),
    .RPT_PER(RPT_PER),
    .CNTW   (CNTW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .btn     (btn),
    .btn_dn  (btn_dn),
    .btn_rpt (btn_rpt),
    .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end else begin
      passed++;
    end
  endtask

  function automatic logic raw_at(input int idx);
    if (idx < 0) return 1'b0;
    return hist[idx];
  endfunction

  // Reference model: btn flips once the input, seen two edges late, has
  // disagreed with it for DB_CYC consecutive edges. The pulse and long outputs
  // follow from the distance to the press edge.
  always @(posedge clk) begin
    exp_t e;
    logic flip;
    int   d;
    edge_cnt++;
    e.edge_no = edge_cnt;
    if (rst) begin
      hist[edge_cnt] = 1'b0;
      if (edge_cnt > 0) hist[edge_cnt-1] = 1'b0;
      m_btn = 1'b0;
      e.btn = 1'b0; e.dn = 1'b0; e.rpt = 1'b0; e.lng = 1'b0;
    end else begin
      hist[edge_cnt] = btn_raw;
      flip = 1'b1;
      for (int j = 0; j < DB_CYC; j++) begin
        if (raw_at(edge_cnt - 2 - j) == m_btn) flip = 1'b0;
      end
      if (flip) begin
        m_btn = ~m_btn;
        if (m_btn) t_press = edge_cnt;
      end
      d     = edge_cnt - t_press;
      e.btn = m_btn;
      e.dn  = m_btn && flip;
      e.rpt = m_btn && (d == 0 || (d >= RPT_DLY && (d - RPT_DLY) % RPT_PER == 0));
      e.lng = m_btn && d >= RPT_DLY;
    end
    sb.push_back(e);
    pushes++;
  end

  // Monitor: compare each cycle's outputs away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      pops++;
      check($sformatf("btn@%0d", e.edge_no), 32'(btn), 32'(e.btn));
      check($sformatf("btn_dn@%0d", e.edge_no), 32'(btn_dn), 32'(e.dn));
      check($sformatf("btn_rpt@%0d", e.edge_no), 32'(btn_rpt), 32'(e.rpt));
      check($sformatf("btn_long@%0d", e.edge_no), 32'(btn_long), 32'(e.lng));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits up to a cycle budget for btn to rise; returns edges elapsed or -1.
  task automatic wait_btn_rise(input int start, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (btn === 1'b1) begin
        lat = edge_cnt - start;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int lat;
    logic lvl;
    rst = 1'b1;
    btn_raw = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Clean press: btn, btn_dn and btn_rpt six edges later.
    e0 = edge_cnt;
    btn_raw = 1'b1;
    wait_btn_rise(e0, lat);
    check("press_latency", 32'(lat), 32'd6);
    check("press_dn", 32'(btn_dn), 32'd1);
    // Hold 30 cycles through the repeat train, then release in REPEAT.
    tick(30);
    btn_raw = 1'b0;
    tick(12);

    // Short glitch is filtered.
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(10);

    // Reset while repeating, button still held: press re-qualifies.
    btn_raw = 1'b1;
    tick(22);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    e0 = edge_cnt;
    wait_btn_rise(e0, lat);
    check("rst_requal_latency", 32'(lat), 32'd6);
    tick(8);
    btn_raw = 1'b0;
    tick(10);

    // Bounce every 2 cycles for 40 cycles.
    lvl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      lvl = ~lvl;
      btn_raw = lvl;
      tick(2);
    end
    btn_raw = 1'b0;
    tick(10);

    // Random levels with random hold times and occasional reset.
    for (int i = 0; i < 120; i++) begin
      btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(1, (i % 3 == 0) ? 30 : 7));
    end
    btn_raw = 1'b0;
    tick(12);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(pops), 32'(pushes));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
